self_ex_slink_chn_mon: RTL and testbench

Per-channel SLINK receive monitor for the self-test extension card. It observes frame-completion strobes, CRC results and PHY lock for two SLINK channels, and runs a small qualification state machine per channel. It drives the `chn_slink_err[1:0]` vector consumed directly by the SLINK diagnose stage, which merges it into the card-level `slink_err`. It also keeps saturating per-channel CRC error counters for maintenance readout.

---
 rtl/self_ex_slink_chn_mon.sv | 142 ++++++++++++++
 tb/tb_self_ex_slink_chn_mon.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/self_ex_slink_chn_mon.sv
// SLINK receive monitor: per-channel link qualification FSM, frame timeout
// and saturating CRC error counters for two independent channels.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_DOWN | channel not qualified, counting consecutive good frames
// ST_OK   | channel qualified, counting consecutive bad frames
module self_ex_slink_chn_mon #(
    parameter int TIMEOUT_CYC = 1250,
    parameter int ERR_THRESH  = 3,
    parameter int RECOVER_CNT = 4
) (
    input  logic        clk_12_5m,
    input  logic        rst_12_5m,
    input  logic [1:0]  chn_link_up,
    input  logic [1:0]  chn_rx_vld,
    input  logic [1:0]  chn_rx_crc_ok,
    input  logic        cnt_clr,
    output logic [1:0]  chn_slink_err,
    output logic [15:0] chn0_crc_err_cnt,
    output logic [15:0] chn1_crc_err_cnt
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int GW = $clog2(RECOVER_CNT + 1);
    localparam int BW = $clog2(ERR_THRESH + 1);

    typedef enum logic {
        ST_DOWN = 1'b0,
        ST_OK   = 1'b1
    } state_t;

    logic [1:0]  err_q;
    logic [15:0] crc_cnt [2];

    for (genvar i = 0; i < 2; i++) begin : g_chn
        logic          good_frm;
        logic          bad_frm;
        logic          link_loss;
        logic          tout;
        logic [TW-1:0] tmr_q, tmr_d;
        logic [GW-1:0] good_q, good_d, good_inc;
        logic [BW-1:0] bad_q, bad_d, bad_inc;
        logic [15:0]   crc_q, crc_d;
        state_t        state_q, state_d;

        // Link loss masks any strobe in the same cycle.
        assign link_loss = ~chn_link_up[i];
        assign good_frm  = chn_rx_vld[i] & chn_rx_crc_ok[i] & chn_link_up[i];
        assign bad_frm   = chn_rx_vld[i] & ~chn_rx_crc_ok[i] & chn_link_up[i];
        assign tout      = chn_link_up[i] & ~chn_rx_vld[i] &
                           (tmr_q == TW'(TIMEOUT_CYC - 1));
        assign good_inc  = good_q + 1'b1;
        assign bad_inc   = bad_q + 1'b1;

        always_comb begin
            tmr_d = tmr_q;
            if (link_loss || chn_rx_vld[i]) begin
                tmr_d = '0;
            end else if (tmr_q != TW'(TIMEOUT_CYC)) begin
                tmr_d = tmr_q + 1'b1;
            end
        end

        always_comb begin
            crc_d = crc_q;
            if (cnt_clr) begin
                crc_d = '0;
            end else if (bad_frm && (crc_q != 16'hFFFF)) begin
                crc_d = crc_q + 16'd1;
            end
        end

        always_comb begin
            state_d = state_q;
            good_d  = good_q;
            bad_d   = bad_q;
            case (state_q)
                ST_DOWN: begin
                    if (good_frm) begin
                        if (good_inc == GW'(RECOVER_CNT)) begin
                            state_d = ST_OK;
                            good_d  = '0;
                            bad_d   = '0;
                        end else begin
                            good_d = good_inc;
                        end
                    end else if (bad_frm || tout || link_loss) begin
                        good_d = '0;
                    end
                end
                ST_OK: begin
                    if (link_loss || tout) begin
                        state_d = ST_DOWN;
                        good_d  = '0;
                        bad_d   = '0;
                    end else if (bad_frm) begin
                        if (bad_inc == BW'(ERR_THRESH)) begin
                            state_d = ST_DOWN;
                            good_d  = '0;
                            bad_d   = '0;
                        end else begin
                            bad_d = bad_inc;
                        end
                    end else if (good_frm) begin
                        bad_d = '0;
                    end
                end
                default: begin
                    state_d = ST_DOWN;
                    good_d  = '0;
                    bad_d   = '0;
                end
            endcase
        end

        always_ff @(posedge clk_12_5m) begin
            if (rst_12_5m) begin
                state_q  <= ST_DOWN;
                good_q   <= '0;
                bad_q    <= '0;
                tmr_q    <= '0;
                crc_q    <= '0;
                err_q[i] <= 1'b1;
            end else begin
                state_q  <= state_d;
                good_q   <= good_d;
                bad_q    <= bad_d;
                tmr_q    <= tmr_d;
                crc_q    <= crc_d;
                err_q[i] <= (state_d == ST_DOWN);
            end
        end

        assign crc_cnt[i] = crc_q;
    end

    assign chn_slink_err    = err_q;
    assign chn0_crc_err_cnt = crc_cnt[0];
    assign chn1_crc_err_cnt = crc_cnt[1];

endmodule

// File: tb/tb_self_ex_slink_chn_mon.sv
// Directed checks of qualification, thresholds, timeout, link loss and CRC
// counters, plus a random traffic phase compared against a behavioural model.
module tb_self_ex_slink_chn_mon;

    localparam int T_CYC = 1250;
    localparam int E_THR = 3;
    localparam int R_CNT = 4;

    logic        clk_12_5m = 1'b0;
    logic        rst_12_5m;
    logic [1:0]  chn_link_up;
    logic [1:0]  chn_rx_vld;
    logic [1:0]  chn_rx_crc_ok;
    logic        cnt_clr;
    logic [1:0]  chn_slink_err;
    logic [15:0] chn0_crc_err_cnt;
    logic [15:0] chn1_crc_err_cnt;

    int checks = 0;
    int errors = 0;

    bit m_down [2];
    int m_good [2];
    int m_bad  [2];
    int m_tmr  [2];
    int m_crc  [2];

    always #5 clk_12_5m = ~clk_12_5m;

    self_ex_slink_chn_mon #(
        .TIMEOUT_CYC (T_CYC),
        .ERR_THRESH  (E_THR),
        .RECOVER_CNT (R_CNT)
    ) dut (
        .clk_12_5m        (clk_12_5m),
        .rst_12_5m        (rst_12_5m),
        .chn_link_up      (chn_link_up),
        .chn_rx_vld       (chn_rx_vld),
        .chn_rx_crc_ok    (chn_rx_crc_ok),
        .cnt_clr          (cnt_clr),
        .chn_slink_err    (chn_slink_err),
        .chn0_crc_err_cnt (chn0_crc_err_cnt),
        .chn1_crc_err_cnt (chn1_crc_err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural model, advanced with the inputs seen at the coming edge.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            bit lu, loss, v, good, bad, tout;
            if (rst_12_5m) begin
                m_down[i] = 1'b1;
                m_good[i] = 0;
                m_bad[i]  = 0;
                m_tmr[i]  = 0;
                m_crc[i]  = 0;
            end else begin
                lu   = chn_link_up[i];
                loss = !lu;
                v    = chn_rx_vld[i] && lu;
                good = v && chn_rx_crc_ok[i];
                bad  = v && !chn_rx_crc_ok[i];
                tout = lu && !chn_rx_vld[i] && (m_tmr[i] == T_CYC - 1);
                if (loss || chn_rx_vld[i]) m_tmr[i] = 0;
                else if (m_tmr[i] < T_CYC) m_tmr[i]++;
                if (cnt_clr) m_crc[i] = 0;
                else if (bad && m_crc[i] < 65535) m_crc[i]++;
                if (m_down[i]) begin
                    if (good) begin
                        m_good[i]++;
                        if (m_good[i] == R_CNT) begin
                            m_down[i] = 1'b0;
                            m_good[i] = 0;
                            m_bad[i]  = 0;
                        end
                    end else if (bad || tout || loss) begin
                        m_good[i] = 0;
                    end
                end else begin
                    if (loss || tout) begin
                        m_down[i] = 1'b1;
                        m_good[i] = 0;
                        m_bad[i]  = 0;
                    end else if (bad) begin
                        m_bad[i]++;
                        if (m_bad[i] == E_THR) begin
                            m_down[i] = 1'b1;
                            m_good[i] = 0;
                            m_bad[i]  = 0;
                        end
                    end else if (good) begin
                        m_bad[i] = 0;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_12_5m);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic frame(input int ch, input bit good);
        chn_rx_vld[ch]    = 1'b1;
        chn_rx_crc_ok[ch] = good;
        tick();
        chn_rx_vld        = 2'b00;
        chn_rx_crc_ok     = 2'b00;
    endtask

    initial begin
        logic [5:0] thr_pat;
        logic [7:0] rq_pat;

        // Reset with every input active: reset must win.
        rst_12_5m     = 1'b1;
        chn_link_up   = 2'b11;
        chn_rx_vld    = 2'b11;
        chn_rx_crc_ok = 2'b11;
        cnt_clr       = 1'b0;
        idle(2);
        chk("rst_err", chn_slink_err, 2'b11);
        chk("rst_cnt0", chn0_crc_err_cnt, 16'h0000);
        chk("rst_cnt1", chn1_crc_err_cnt, 16'h0000);
        rst_12_5m     = 1'b0;
        chn_rx_vld    = 2'b00;
        chn_rx_crc_ok = 2'b00;
        tick();
        chk("post_rst_err", chn_slink_err, 2'b11);

        // Qualification of channel 0 with frames 10 cycles apart.
        for (int k = 0; k < 4; k++) begin
            idle(9);
            chk("qual_gap", chn_slink_err, 2'b11);
            frame(0, 1'b1);
            chk("qual", chn_slink_err, (k == 3) ? 2'b10 : 2'b11);
        end

        // bad, bad, good, bad, bad, bad: only the third bad of the last run drops.
        thr_pat = 6'b000100;
        for (int j = 0; j < 6; j++) begin
            idle(1);
            frame(0, thr_pat[j]);
            chk("thresh", chn_slink_err[0], (j == 5) ? 1'b1 : 1'b0);
        end
        chk("thresh_cnt0", chn0_crc_err_cnt, 16'd5);

        // Timeout on channel 1: last frame at edge T, error after edge T+1250.
        for (int k = 0; k < 4; k++) begin
            frame(1, 1'b1);
            chk("qual1", chn_slink_err, (k == 3) ? 2'b01 : 2'b11);
        end
        idle(T_CYC - 1);
        chk("tout_edge_m1", chn_slink_err[1], 1'b0);
        idle(1);
        chk("tout_edge", chn_slink_err[1], 1'b1);

        for (int k = 0; k < 4; k++) frame(1, 1'b1);
        chk("requal1", chn_slink_err[1], 1'b0);
        idle(T_CYC - 2);
        frame(1, 1'b1);
        chk("tout_saved", chn_slink_err[1], 1'b0);
        idle(T_CYC - 1);
        chk("tout2_edge_m1", chn_slink_err[1], 1'b0);
        idle(1);
        chk("tout2_edge", chn_slink_err[1], 1'b1);

        // Link loss dominates a simultaneous bad strobe.
        for (int k = 0; k < 4; k++) frame(0, 1'b1);
        chk("requal0", chn_slink_err, 2'b10);
        chn_link_up   = 2'b10;
        chn_rx_vld    = 2'b01;
        chn_rx_crc_ok = 2'b00;
        tick();
        chn_link_up   = 2'b11;
        chn_rx_vld    = 2'b00;
        chk("loss_err", chn_slink_err, 2'b11);
        chk("loss_cnt0", chn0_crc_err_cnt, 16'd5);

        // good x3, bad, good x4: requalifies only on the final good frame.
        rq_pat = 8'b11110111;
        for (int j = 0; j < 8; j++) begin
            frame(0, rq_pat[j]);
            chk("requal_run", chn_slink_err[0], (j == 7) ? 1'b0 : 1'b1);
        end
        chk("requal_cnt0", chn0_crc_err_cnt, 16'd6);

        // Random traffic on both channels against the model.
        for (int n = 0; n < 3000; n++) begin
            chn_link_up[0]   = ($urandom_range(63) != 0);
            chn_link_up[1]   = ($urandom_range(63) != 0);
            chn_rx_vld[0]    = ($urandom_range(2) == 0);
            chn_rx_vld[1]    = ($urandom_range(2) == 0);
            chn_rx_crc_ok[0] = ($urandom_range(5) != 0);
            chn_rx_crc_ok[1] = ($urandom_range(5) != 0);
            cnt_clr          = ($urandom_range(63) == 0);
            tick();
            chk("rnd_err", chn_slink_err, {m_down[1], m_down[0]});
            chk("rnd_cnt0", chn0_crc_err_cnt, m_crc[0]);
            chk("rnd_cnt1", chn1_crc_err_cnt, m_crc[1]);
        end
        chn_link_up   = 2'b11;
        chn_rx_vld    = 2'b00;
        chn_rx_crc_ok = 2'b00;
        cnt_clr       = 1'b0;

        // Clear wins over a simultaneous bad frame, then saturate channel 1.
        chn_rx_vld = 2'b10;
        cnt_clr    = 1'b1;
        tick();
        cnt_clr    = 1'b0;
        chk("clr_cnt0", chn0_crc_err_cnt, 16'h0000);
        chk("clr_cnt1", chn1_crc_err_cnt, 16'h0000);
        idle(65534);
        chk("sat_fffe", chn1_crc_err_cnt, 16'hFFFE);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("sat_ffff", chn1_crc_err_cnt, 16'hFFFF);
        end
        chk("sat_cnt0", chn0_crc_err_cnt, 16'h0000);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("sat_clr", chn1_crc_err_cnt, 16'h0000);
        tick();
        chn_rx_vld = 2'b00;
        chk("sat_after_clr", chn1_crc_err_cnt, 16'h0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
